// File: rtl/poly_tone_player_pkg.sv
// Shared types and constants for the polyphonic tone player.
package poly_tone_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    HOLD = 2'd2
  } chan_state_t;

  localparam logic [1:0] PIEZO_OFF = 2'b00;

  localparam int CMD_DIV_W = 16;
  localparam int CMD_DUR_W = 8;

  // Command word at the default field widths, as produced by the tune sequencer.
  typedef struct packed {
    logic [1:0]           chan;
    logic [CMD_DIV_W-1:0] period;
    logic [CMD_DUR_W-1:0] dur;
  } tone_cmd_t;

endpackage

// File: rtl/poly_tone_player_if.sv
// Shared note command port: channel, half-period and duration with valid/ready.
interface poly_tone_player_if #(
  parameter int DIV_W = 16,
  parameter int DUR_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_chan;
  logic [DIV_W-1:0] cmd_period;
  logic [DUR_W-1:0] cmd_dur;

  modport master (output cmd_valid, cmd_chan, cmd_period, cmd_dur, input cmd_ready);
  modport slave  (input cmd_valid, cmd_chan, cmd_period, cmd_dur, output cmd_ready);
endinterface

// File: rtl/poly_tone_player_tone_channel.sv
// One tone channel: pending slot, IDLE/PLAY/HOLD FSM, half-period divider and duration counter.
module tone_channel
  import poly_tone_pkg::*;
#(
  parameter int DIV_W = 16,
  parameter int DUR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             tick,
  input  logic             load,
  input  logic [DIV_W-1:0] load_period,
  input  logic [DUR_W-1:0] load_dur,
  output logic [1:0]       pins,
  output logic             busy,
  output logic             note_done,
  output logic             pend_valid
);

  chan_state_t      state;
  logic [DIV_W-1:0] pend_period;
  logic [DUR_W-1:0] pend_dur;
  logic [DIV_W-1:0] period;
  logic [DUR_W-1:0] remaining;
  logic [DIV_W-1:0] half_cnt;
  logic             phase;
  logic             promote;
  logic             finish;

  // load only happens with the slot empty and promote only with it full,
  // so the two never collide on pend_valid.
  always_comb begin
    promote = 1'b0;
    finish  = 1'b0;
    if (ena) begin
      case (state)
        IDLE: promote = pend_valid;
        PLAY: begin
          if (tick && remaining == DUR_W'(1)) begin
            promote = pend_valid;
            finish  = !pend_valid;
          end
        end
        HOLD:    promote = tick && pend_valid;
        default: promote = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pend_valid  <= 1'b0;
      pend_period <= '0;
      pend_dur    <= '0;
      period      <= '0;
      remaining   <= '0;
      half_cnt    <= '0;
      phase       <= 1'b0;
      note_done   <= 1'b0;
    end else begin
      note_done <= 1'b0;
      if (load) begin
        pend_valid  <= 1'b1;
        pend_period <= load_period;
        pend_dur    <= load_dur;
      end
      if (promote) begin
        state      <= (pend_dur != '0) ? PLAY : HOLD;
        period     <= pend_period;
        remaining  <= pend_dur;
        half_cnt   <= '0;
        phase      <= 1'b0;
        pend_valid <= 1'b0;
      end else if (finish) begin
        state     <= IDLE;
        note_done <= 1'b1;
      end else if (ena && state != IDLE) begin
        if (state == PLAY && tick) begin
          remaining <= remaining - 1'b1;
        end
        if (period != '0) begin
          if (half_cnt == period - 1'b1) begin
            half_cnt <= '0;
            phase    <= ~phase;
          end else begin
            half_cnt <= half_cnt + 1'b1;
          end
        end
      end
    end
  end

  assign busy = (state != IDLE);
  assign pins = (busy && period != '0 && ena) ? {~phase, phase} : PIEZO_OFF;

endmodule

// File: rtl/poly_tone_player.sv
// Polyphonic square-wave tone player: shared prescaler, command demux and ready mux.
module poly_tone_player
  import poly_tone_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int DIV_W    = 16,
  parameter int DUR_W    = 8,
  parameter int TICK_DIV = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  poly_tone_player_if.slave     cmd,
  output logic [2*CHANNELS-1:0] piezo,
  output logic [CHANNELS-1:0]   busy,
  output logic [CHANNELS-1:0]   note_done
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0]       presc;
  logic                tick;
  logic [CHANNELS-1:0] pend_valid;
  logic [3:0]          pend_pad;

  assign tick = ena && (presc == PW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (ena) begin
      presc <= tick ? '0 : presc + 1'b1;
    end
  end

  // Unpopulated channel slots read as empty, so out-of-range commands are taken and dropped.
  always_comb begin
    pend_pad                 = '0;
    pend_pad[CHANNELS-1:0]   = pend_valid;
  end

  assign cmd.cmd_ready = ~pend_pad[cmd.cmd_chan];

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    tone_channel #(
      .DIV_W (DIV_W),
      .DUR_W (DUR_W)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .ena         (ena),
      .tick        (tick),
      .load        (cmd.cmd_valid && cmd.cmd_chan == 2'(i) && !pend_valid[i]),
      .load_period (cmd.cmd_period),
      .load_dur    (cmd.cmd_dur),
      .pins        (piezo[2*i+1:2*i]),
      .busy        (busy[i]),
      .note_done   (note_done[i]),
      .pend_valid  (pend_valid[i])
    );
  end

endmodule

// File: tb/tb_poly_tone_player.sv
// Self-checking bench for poly_tone_player (CHANNELS=2, TICK_DIV=4) against a note-timeline model.
module tb_poly_tone_player;

  localparam int NCH = 2;
  localparam int TD  = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [3:0] piezo;
  logic [1:0] busy;
  logic [1:0] note_done;

  int checks = 0;
  int errors = 0;

  poly_tone_player_if #(.DIV_W(16), .DUR_W(8)) cmd_bus ();

  poly_tone_player #(
    .CHANNELS (NCH),
    .DIV_W    (16),
    .DUR_W    (8),
    .TICK_DIV (TD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .cmd       (cmd_bus),
    .piezo     (piezo),
    .busy      (busy),
    .note_done (note_done)
  );

  always #5 clk = ~clk;

  // Model: e counts enabled clock edges since reset; every TD-th enabled edge is a tick.
  // A note started at edge s has phase ((e-s)/period)%2 and, if timed, ends on the
  // dur-th tick strictly after s.
  int         e;
  bit         m_act [NCH];
  int         m_per [NCH];
  int         m_dur [NCH];
  int         m_start [NCH];
  int         m_end [NCH];
  bit         m_pend [NCH];
  int         p_per [NCH];
  int         p_dur [NCH];
  logic [3:0] exp_piezo;
  logic [1:0] exp_busy;
  logic [1:0] exp_done;
  logic [7:0] got;
  logic [7:0] want;

  function automatic bit model_ready(int ch);
    return (ch >= NCH) || !m_pend[ch];
  endfunction

  task automatic model_outputs();
    exp_piezo = '0;
    exp_busy  = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      exp_busy[ch] = m_act[ch];
      if (m_act[ch] && m_per[ch] != 0 && ena)
        exp_piezo[2*ch +: 2] = (((e - m_start[ch]) / m_per[ch]) % 2 != 0) ? 2'b01 : 2'b10;
    end
  endtask

  task automatic model_reset();
    e = 0;
    for (int ch = 0; ch < NCH; ch++) begin
      m_act[ch] = 0; m_pend[ch] = 0; m_per[ch] = 0; m_dur[ch] = 0;
      m_start[ch] = 0; m_end[ch] = 0; p_per[ch] = 0; p_dur[ch] = 0;
    end
    exp_done = '0;
    model_outputs();
  endtask

  task automatic model_edge();
    bit acc;
    bit tick;
    bit promote;
    int c;
    if (!rst_n) begin
      model_reset();
      return;
    end
    exp_done = '0;
    c   = int'(cmd_bus.cmd_chan);
    acc = cmd_bus.cmd_valid && model_ready(c);
    if (ena) begin
      e++;
      tick = (e % TD == 0);
      for (int ch = 0; ch < NCH; ch++) begin
        promote = 0;
        if (!m_act[ch]) promote = m_pend[ch];
        else if (m_dur[ch] == 0) promote = tick && m_pend[ch];
        else if (e == m_end[ch]) begin
          if (m_pend[ch]) promote = 1;
          else begin
            m_act[ch]    = 0;
            exp_done[ch] = 1'b1;
          end
        end
        if (promote) begin
          m_act[ch]   = 1;
          m_per[ch]   = p_per[ch];
          m_dur[ch]   = p_dur[ch];
          m_start[ch] = e;
          m_end[ch]   = ((e / TD) + p_dur[ch]) * TD;
          m_pend[ch]  = 0;
        end
      end
    end
    if (acc && c < NCH) begin
      m_pend[c] = 1;
      p_per[c]  = int'(cmd_bus.cmd_period);
      p_dur[c]  = int'(cmd_bus.cmd_dur);
    end
    model_outputs();
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    got  = {piezo, busy, note_done};
    want = {exp_piezo, exp_busy, exp_done};
  endtask

  // Holds the command until the model says it is taken; returns just after the accepting edge.
  task automatic send(input int ch, input int per, input int dur);
    cmd_bus.cmd_chan   = 2'(ch);
    cmd_bus.cmd_period = 16'(per);
    cmd_bus.cmd_dur    = 8'(dur);
    cmd_bus.cmd_valid  = 1'b1;
    for (int k = 0; k < 200; k++) begin
      if (model_ready(ch)) begin
        step();
        cmd_bus.cmd_valid = 1'b0;
        return;
      end
      step();
    end
    cmd_bus.cmd_valid = 1'b0;
    checks++;
    errors++;
    $display("FAIL send_timeout ch=%0d never accepted, required acceptance within 200 cycles", ch);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ena   = 1'b1;
    cmd_bus.cmd_valid = 1'b0;
    cmd_bus.cmd_chan = '0; cmd_bus.cmd_period = '0; cmd_bus.cmd_dur = '0;
    model_reset();
    repeat (3) step();
    checks++;
    if ({piezo, busy, note_done} !== 8'h00 || cmd_bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state got piezo=%b busy=%b done=%b ready=%b exp 0000 00 00 1",
               piezo, busy, note_done, cmd_bus.cmd_ready);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      checks++;
      if (got !== 8'h00) begin
        errors++;
        $display("FAIL reset_idle cycle %0d got %b exp 00000000", i, got);
      end
    end
  endtask

  task automatic test_single_note();
    int dones = 0;
    send(0, 3, 2);
    step();
    checks++;
    if (piezo !== 4'b0010) begin
      errors++;
      $display("FAIL single_first got piezo=%b exp 0010", piezo);
    end
    dones += note_done[0];
    for (int i = 0; i < 24; i++) begin
      step();
      dones += note_done[0];
      checks++;
      if (got !== want || piezo[3:2] !== 2'b00) begin
        errors++;
        $display("FAIL single_note cycle %0d got %b exp %b", i, got, want);
      end
    end
    checks++;
    if (dones !== 1) begin
      errors++;
      $display("FAIL single_done_count got %0d exp 1", dones);
    end
  endtask

  task automatic test_gapless();
    int dones = 0;
    send(0, 3, 2);
    cmd_bus.cmd_period = 16'd5;
    cmd_bus.cmd_dur    = 8'd1;
    cmd_bus.cmd_chan   = 2'd0;
    cmd_bus.cmd_valid  = 1'b1;
    #1;
    checks++;
    if (cmd_bus.cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL gapless_ready_full got %b exp 0", cmd_bus.cmd_ready);
    end
    cmd_bus.cmd_chan = 2'd1;
    #1;
    checks++;
    if (cmd_bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL gapless_ready_other got %b exp 1", cmd_bus.cmd_ready);
    end
    cmd_bus.cmd_valid = 1'b0;
    send(0, 5, 1);
    dones += note_done[0];
    for (int i = 0; i < 40; i++) begin
      step();
      dones += note_done[0];
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL gapless cycle %0d got %b exp %b", i, got, want);
      end
    end
    checks++;
    if (dones !== 1) begin
      errors++;
      $display("FAIL gapless_done_count got %0d exp 1", dones);
    end
  endtask

  task automatic test_hold_replace();
    int dones = 0;
    send(1, 4, 0);
    for (int i = 0; i < 100 * TD; i++) begin
      step();
      dones += note_done[1];
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL hold cycle %0d got %b exp %b", i, got, want);
      end
    end
    send(1, 2, 3);
    dones += note_done[1];
    for (int i = 0; i < 24; i++) begin
      step();
      dones += note_done[1];
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL replace cycle %0d got %b exp %b", i, got, want);
      end
    end
    checks++;
    if (dones !== 1) begin
      errors++;
      $display("FAIL replace_done_count got %0d exp 1", dones);
    end
  endtask

  task automatic test_rest_and_oor();
    int dones = 0;
    send(0, 0, 3);
    for (int i = 0; i < 20; i++) begin
      step();
      dones += note_done[0];
      checks++;
      if (got !== want || piezo !== 4'b0000) begin
        errors++;
        $display("FAIL rest cycle %0d got %b exp %b", i, got, want);
      end
    end
    checks++;
    if (dones !== 1) begin
      errors++;
      $display("FAIL rest_done_count got %0d exp 1", dones);
    end
    cmd_bus.cmd_chan = 2'd3; cmd_bus.cmd_period = 16'd7; cmd_bus.cmd_dur = 8'd2;
    cmd_bus.cmd_valid = 1'b1;
    #1;
    checks++;
    if (cmd_bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL oor_ready got %b exp 1", cmd_bus.cmd_ready);
    end
    step();
    cmd_bus.cmd_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (got !== want || busy !== 2'b00) begin
        errors++;
        $display("FAIL oor_dropped cycle %0d got %b exp %b", i, got, want);
      end
    end
  endtask

  task automatic test_freeze_and_reset();
    int dones = 0;
    send(0, 3, 5);
    for (int i = 0; i < 46; i++) begin
      if (i == 6)  ena = 1'b0;
      if (i == 16) ena = 1'b1;
      step();
      dones += note_done[0];
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL freeze cycle %0d ena=%b got %b exp %b", i, ena, got, want);
      end
    end
    checks++;
    if (dones !== 1) begin
      errors++;
      $display("FAIL freeze_done_count got %0d exp 1", dones);
    end
    send(1, 2, 0);
    repeat (5) step();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (piezo !== 4'b0000 || busy !== 2'b00) begin
      errors++;
      $display("FAIL async_reset got piezo=%b busy=%b exp 0000 00", piezo, busy);
    end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL post_reset cycle %0d got %b exp %b", i, got, want);
      end
    end
  endtask

  task automatic test_random();
    poly_tone_pkg::tone_cmd_t c;
    for (int i = 0; i < 800; i++) begin
      c.chan   = 2'($urandom_range(0, 3));
      c.period = 16'($urandom_range(0, 6));
      c.dur    = 8'($urandom_range(0, 3));
      ena               = ($urandom_range(0, 9) != 0);
      cmd_bus.cmd_valid = ($urandom_range(0, 1) != 0);
      cmd_bus.cmd_chan   = c.chan;
      cmd_bus.cmd_period = c.period;
      cmd_bus.cmd_dur    = c.dur;
      #1;
      checks++;
      if (cmd_bus.cmd_ready !== model_ready(int'(c.chan))) begin
        errors++;
        $display("FAIL random_ready cycle %0d chan=%0d got %b exp %b",
                 i, c.chan, cmd_bus.cmd_ready, model_ready(int'(c.chan)));
      end
      step();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL random cycle %0d got %b exp %b", i, got, want);
      end
    end
    cmd_bus.cmd_valid = 1'b0;
    ena = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single_note();
    test_gapless();
    test_hold_replace();
    test_rest_and_oor();
    test_freeze_and_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
